// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - issue/datapath handshake bundle for the mul/div sequencer
interface muldiv_sequencer_if;
  logic       Start;
  logic       Op;
  logic       Div_zero;
  logic       LSB;
  logic       Rem_sign;
  logic       W_ctrl;
  logic [5:0] ALU_ctrl;
  logic       W_acc;
  logic       SRL_ctrl;
  logic       SLL_ctrl;
  logic       Q_bit;
  logic       Busy;
  logic       Ready;
  logic       Div_err;

  modport master (
    output Start, Op, Div_zero, LSB, Rem_sign,
    input  W_ctrl, ALU_ctrl, W_acc, SRL_ctrl, SLL_ctrl, Q_bit, Busy, Ready, Div_err
  );

  modport slave (
    input  Start, Op, Div_zero, LSB, Rem_sign,
    output W_ctrl, ALU_ctrl, W_acc, SRL_ctrl, SLL_ctrl, Q_bit, Busy, Ready, Div_err
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - FSM sequencing shift-add multiply and restoring divide
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              Reset,
  muldiv_sequencer_if.slave bus
);
  localparam logic [5:0]       ALU_ADDU  = 6'b001001;
  localparam logic [5:0]       ALU_SUBU  = 6'b100011;
  localparam logic [5:0]       ALU_NONE  = 6'b100010;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL_STEP,
    DIV_SUB,
    DIV_FIX,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_q, op_nxt;
  logic             err_q, err_nxt;

  logic       w_ctrl, w_acc, srl_ctrl, sll_ctrl, q_bit, busy, ready, div_err;
  logic [5:0] alu_ctrl;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    err_nxt   = err_q;
    w_ctrl    = 1'b0;
    w_acc     = 1'b0;
    srl_ctrl  = 1'b0;
    sll_ctrl  = 1'b0;
    q_bit     = 1'b0;
    ready     = 1'b0;
    div_err   = 1'b0;
    alu_ctrl  = ALU_NONE;
    busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (bus.Start) begin
          state_nxt = LOAD;
          op_nxt    = bus.Op;
          err_nxt   = 1'b0;
        end
      end
      LOAD: begin
        w_ctrl  = 1'b1;
        cnt_nxt = '0;
        if (!op_q) begin
          state_nxt = MUL_STEP;
        end else if (bus.Div_zero) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = DIV_SUB;
        end
      end
      MUL_STEP: begin
        srl_ctrl = 1'b1;
        if (bus.LSB) begin
          alu_ctrl = ALU_ADDU;
          w_acc    = 1'b1;
        end
        if (cnt == LAST_ITER) state_nxt = DONE;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      DIV_SUB: begin
        alu_ctrl  = ALU_SUBU;
        w_acc     = 1'b1;
        state_nxt = DIV_FIX;
      end
      DIV_FIX: begin
        sll_ctrl = 1'b1;
        // Negative trial remainder: add the divisor back and shift in a 0.
        if (bus.Rem_sign) begin
          alu_ctrl = ALU_ADDU;
          w_acc    = 1'b1;
        end else begin
          q_bit = 1'b1;
        end
        if (cnt == LAST_ITER) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = DIV_SUB;
        end
      end
      DONE: begin
        ready     = 1'b1;
        div_err   = err_q;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.W_ctrl   = w_ctrl;
  assign bus.ALU_ctrl = alu_ctrl;
  assign bus.W_acc    = w_acc;
  assign bus.SRL_ctrl = srl_ctrl;
  assign bus.SLL_ctrl = sll_ctrl;
  assign bus.Q_bit    = q_bit;
  assign bus.Busy     = busy;
  assign bus.Ready    = ready;
  assign bus.Div_err  = div_err;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  localparam int         WIDTH = 32;
  localparam logic [5:0] ADDU  = 6'b001001;
  localparam logic [5:0] SUBU  = 6'b100011;
  localparam logic [5:0] NONE  = 6'b100010;

  typedef struct {
    int          lat;
    int          srl_n;
    int          sll_n;
    int          subu_n;
    logic [31:0] add_mask;
    logic [31:0] qbits;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();
  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  resp_t       exp_q[$];
  logic [31:0] opnd_q[$];
  time         rise_t[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what a whole operation should look like from the outside.
  function automatic resp_t model(input logic op, input logic dz, input logic [31:0] opnd);
    resp_t r;
    r.lat = 0; r.srl_n = 0; r.sll_n = 0; r.subu_n = 0;
    r.add_mask = '0; r.qbits = '0; r.err = 1'b0;
    if (!op) begin
      r.lat = WIDTH + 1; r.srl_n = WIDTH; r.add_mask = opnd;
    end else if (dz) begin
      r.lat = 1; r.err = 1'b1;
    end else begin
      r.lat = 2 * WIDTH + 1; r.sll_n = WIDTH; r.subu_n = WIDTH;
      r.add_mask = opnd; r.qbits = ~opnd;
    end
    return r;
  endfunction

  // Datapath stand-in: one shift register supplies LSB (mul) or Rem_sign (div).
  logic [31:0] sreg;
  always @(posedge clk or negedge Reset) begin
    if (!Reset) sreg <= '0;
    else if (bus.W_ctrl) begin
      if (opnd_q.size() > 0) sreg <= opnd_q.pop_front();
    end else if (bus.SRL_ctrl || bus.SLL_ctrl) sreg <= sreg >> 1;
  end
  assign bus.LSB      = sreg[0];
  assign bus.Rem_sign = sreg[0];

  // Monitor: accumulate one operation from Busy rise to Ready, then score it.
  bit    active = 0;
  int    cyc;
  resp_t act;
  always @(negedge clk) begin
    if (!Reset) begin
      active = 0;
    end else begin
      if (bus.Busy && !active) begin
        active = 1; cyc = 0; rise_t.push_back($time);
        act.srl_n = 0; act.sll_n = 0; act.subu_n = 0;
        act.add_mask = '0; act.qbits = '0;
      end
      if (active) begin
        cyc++;
        if (bus.SRL_ctrl) begin
          if (bus.ALU_ctrl == ADDU && bus.W_acc && act.srl_n < 32) act.add_mask[act.srl_n] = 1'b1;
          act.srl_n++;
        end
        if (bus.SLL_ctrl) begin
          if (act.sll_n < 32) begin
            if (bus.ALU_ctrl == ADDU && bus.W_acc) act.add_mask[act.sll_n] = 1'b1;
            act.qbits[act.sll_n] = bus.Q_bit;
          end
          act.sll_n++;
        end
        if (bus.ALU_ctrl == SUBU && bus.W_acc) act.subu_n++;
      end
      if (bus.Ready) begin
        if (exp_q.size() == 0) begin
          chk("ready_without_request", exp_q.size(), 1);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          chk("latency", cyc - 1, e.lat);
          chk("srl_pulses", act.srl_n, e.srl_n);
          chk("sll_pulses", act.sll_n, e.sll_n);
          chk("subu_cycles", act.subu_n, e.subu_n);
          chk("addu_steps", act.add_mask, e.add_mask);
          chk("q_bits", act.qbits, e.qbits);
          chk("div_err", bus.Div_err, e.err);
        end
        active = 0;
      end
    end
  end

  task automatic chk_quiet(input string name);
    chk(name, {bus.W_ctrl, bus.W_acc, bus.SRL_ctrl, bus.SLL_ctrl, bus.Q_bit,
               bus.Busy, bus.Ready, bus.Div_err, bus.ALU_ctrl},
        {8'b0, NONE});
  endtask

  task automatic issue(input logic op, input logic dz, input logic [31:0] opnd);
    @(negedge clk);
    bus.Op = op; bus.Div_zero = dz; bus.Start = 1'b1;
    exp_q.push_back(model(op, dz, opnd));
    opnd_q.push_back(opnd);
    @(negedge clk);
    bus.Start = 1'b0; bus.Op = 1'($urandom);
    @(negedge clk);
    bus.Div_zero = 1'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("op_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] idle_or;
    bus.Start = 1'b0; bus.Op = 1'b0; bus.Div_zero = 1'b0;
    #12;
    chk_quiet("reset_state");
    @(negedge clk);
    Reset = 1'b1;

    idle_or = '0;
    repeat (100) begin
      @(negedge clk);
      idle_or = idle_or | {23'b0, bus.W_ctrl, bus.W_acc, bus.SRL_ctrl, bus.SLL_ctrl,
                           bus.Q_bit, bus.Busy, bus.Ready, bus.Div_err, bus.ALU_ctrl != NONE};
    end
    chk("idle_quiet", idle_or, 0);

    issue(1'b0, 1'b0, 32'h0000_000D);  wait_idle(200);
    issue(1'b1, 1'b0, 32'h5555_5555);  wait_idle(200);
    issue(1'b1, 1'b1, 32'h1234_5678);  wait_idle(200);
    for (int i = 0; i < 10; i++) begin
      logic op, dz;
      op = 1'($urandom);
      dz = ($urandom_range(3) == 0);
      issue(op, dz, $urandom);
      wait_idle(200);
    end

    // Start held high: back-to-back multiplies, Start ignored while busy.
    @(negedge clk);
    rise_t.delete();
    bus.Op = 1'b0; bus.Div_zero = 1'($urandom); bus.Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v;
      v = $urandom;
      exp_q.push_back(model(1'b0, 1'b0, v));
      opnd_q.push_back(v);
    end
    wait_idle(400);
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_op_count", rise_t.size(), 3);
    if (rise_t.size() >= 3) begin
      chk("held_period_0", 32'((rise_t[1] - rise_t[0]) / 10), WIDTH + 3);
      chk("held_period_1", 32'((rise_t[2] - rise_t[1]) / 10), WIDTH + 3);
    end
    chk("held_idle_after", bus.Busy, 0);

    // Asynchronous reset around multiply iteration 10 with ADDU active.
    issue(1'b0, 1'b0, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    #2 Reset = 1'b0;
    #1 chk_quiet("async_reset_outputs");
    void'(exp_q.pop_back());
    opnd_q.delete();
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    chk_quiet("after_reset_release");
    issue(1'b0, 1'b0, 32'hA5A5_0F0F);
    wait_idle(200);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
